sobel_window_gen: RTL and testbench

//   Sink side of the 8-bit raster pixel stream (pixel + valid, no backpressure).

---
 rtl/sobel_window_gen_pkg.sv | 15 +
 rtl/sobel_window_gen_line_buffer.sv | 22 ++
 rtl/sobel_window_gen.sv | 114 +++++++++++
 tb/tb_sobel_window_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_window_gen_pkg.sv
// rtl/sobel_window_gen_pkg.sv - shared constants for the Sobel 3x3 window generator
package sobel_window_gen_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int WIN_TAPS   = 9;
   // Slot k = 3*r + c, r/c counted from the window's top-left pixel
   localparam int WIN_TL = 0;
   localparam int WIN_TC = 1;
   localparam int WIN_TR = 2;
   localparam int WIN_ML = 3;
   localparam int WIN_MC = 4;
   localparam int WIN_MR = 5;
   localparam int WIN_BL = 6;
   localparam int WIN_BC = 7;
   localparam int WIN_BR = 8;
endpackage

// File: rtl/sobel_window_gen_line_buffer.sv
// rtl/sobel_window_gen_line_buffer.sv - column-addressed line store
// Read returns the value held before this cycle's write; contents are never reset.
module sobel_window_gen_line_buffer #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   output logic [DATA_W-1:0]        rd_data
);
   logic [DATA_W-1:0] r_mem [DEPTH];

   assign rd_data = r_mem[addr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[addr] <= wr_data;
      end
   end
endmodule

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - raster pixel sink producing registered 3x3 neighbourhoods
// Two line buffers feed the upper window rows; windows are emitted for interior centres only.
module sobel_window_gen
   import sobel_window_gen_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DATA_W-1:0]            pixel_in,
   input  logic                         valid_in,
   output logic [WIN_TAPS*DATA_W-1:0]   win_out,
   output logic                         win_valid,
   output logic [$clog2(HEIGHT)-1:0]    win_row,
   output logic [$clog2(WIDTH)-1:0]     win_col,
   output logic                         frame_done
);
   localparam int ROW_W = $clog2(HEIGHT);
   localparam int COL_W = $clog2(WIDTH);

   logic [ROW_W-1:0]  r_row;
   logic [COL_W-1:0]  r_col;
   logic [DATA_W-1:0] r_win [WIN_TAPS];
   logic              r_win_valid;
   logic [ROW_W-1:0]  r_win_row;
   logic [COL_W-1:0]  r_win_col;
   logic              r_frame_done;

   logic [DATA_W-1:0] w_lb1_rd;
   logic [DATA_W-1:0] w_lb2_rd;
   logic              w_last_col;
   logic              w_last_row;
   logic              w_emit;

   assign w_last_col = (r_col == COL_W'(WIDTH - 1));
   assign w_last_row = (r_row == ROW_W'(HEIGHT - 1));
   // The row/col >= 2 gate keeps stale left columns and previous-frame lines out of every window
   assign w_emit     = valid_in && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

   sobel_window_gen_line_buffer #(.DEPTH(WIDTH), .DATA_W(DATA_W)) u_lb1 (
      .clk     (clk),
      .addr    (r_col),
      .wr_en   (valid_in),
      .wr_data (pixel_in),
      .rd_data (w_lb1_rd)
   );

   sobel_window_gen_line_buffer #(.DEPTH(WIDTH), .DATA_W(DATA_W)) u_lb2 (
      .clk     (clk),
      .addr    (r_col),
      .wr_en   (valid_in),
      .wr_data (w_lb1_rd),
      .rd_data (w_lb2_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row <= '0;
         r_col <= '0;
      end else if (valid_in) begin
         if (w_last_col) begin
            r_col <= '0;
            r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < WIN_TAPS; k++) begin
            r_win[k] <= '0;
         end
      end else if (valid_in) begin
         r_win[WIN_TL] <= r_win[WIN_TC];
         r_win[WIN_TC] <= r_win[WIN_TR];
         r_win[WIN_TR] <= w_lb2_rd;
         r_win[WIN_ML] <= r_win[WIN_MC];
         r_win[WIN_MC] <= r_win[WIN_MR];
         r_win[WIN_MR] <= w_lb1_rd;
         r_win[WIN_BL] <= r_win[WIN_BC];
         r_win[WIN_BC] <= r_win[WIN_BR];
         r_win[WIN_BR] <= pixel_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win_valid  <= 1'b0;
         r_win_row    <= '0;
         r_win_col    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_win_valid  <= w_emit;
         r_frame_done <= valid_in && w_last_col && w_last_row;
         if (w_emit) begin
            r_win_row <= r_row - ROW_W'(1);
            r_win_col <= r_col - COL_W'(1);
         end
      end
   end

   for (genvar k = 0; k < WIN_TAPS; k++) begin : g_pack
      assign win_out[k*DATA_W +: DATA_W] = r_win[k];
   end

   assign win_valid  = r_win_valid;
   assign win_row    = r_win_row;
   assign win_col    = r_win_col;
   assign frame_done = r_frame_done;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - scoreboard bench for sobel_window_gen
module tb_sobel_window_gen;
   localparam int W  = 8;
   localparam int H  = 8;
   localparam int DW = 8;
   localparam int WB = 9 * DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] pixel_in;
   logic          valid_in;
   logic [WB-1:0] win_out;
   logic          win_valid;
   logic [2:0]    win_row;
   logic [2:0]    win_col;
   logic          frame_done;

   sobel_window_gen #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pixel_in   (pixel_in),
      .valid_in   (valid_in),
      .win_out    (win_out),
      .win_valid  (win_valid),
      .win_row    (win_row),
      .win_col    (win_col),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WB-1:0] win;
      logic [2:0]    row;
      logic [2:0]    col;
      logic          fd;
   } exp_t;

   exp_t          sb[$];
   exp_t          e;
   logic [DW-1:0] img [H][W];
   logic [WB-1:0] obs_win [H][W];
   int            m_row, m_col;
   int            n_checks = 0;
   int            n_errors = 0;
   int            win_cnt, fd_cnt;
   logic          acc_q = 1'b0;
   logic          prev_wv = 1'b0;
   logic          tog_mode = 1'b0;

   task automatic check_eq(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [WB-1:0] pack9(input int s0, s1, s2, s3, s4, s5, s6, s7, s8);
      logic [DW-1:0] b [9];
      logic [WB-1:0] v;
      b = '{DW'(s0), DW'(s1), DW'(s2), DW'(s3), DW'(s4), DW'(s5), DW'(s6), DW'(s7), DW'(s8)};
      for (int k = 0; k < 9; k++) v[k*DW +: DW] = b[k];
      return v;
   endfunction

   task automatic idle_cycle();
      valid_in = 1'b0;
      pixel_in = DW'($urandom);
      @(posedge clk);
      #1;
   endtask

   task automatic push_pixel(input logic [DW-1:0] val);
      exp_t x;
      img[m_row][m_col] = val;
      if (m_row >= 2 && m_col >= 2) begin
         for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
               x.win[(3*rr+cc)*DW +: DW] = img[m_row-2+rr][m_col-2+cc];
         x.row = 3'(m_row - 1);
         x.col = 3'(m_col - 1);
         x.fd  = (m_row == H-1) && (m_col == W-1);
         sb.push_back(x);
      end
      pixel_in = val;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      if (m_col == W-1) begin
         m_col = 0;
         m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
         m_col++;
      end
   endtask

   // mode: 0 continuous, 1 idle between pixels, 2 ten idle cycles before each last column
   task automatic send_pixels(input int n, input int offset, input int mode, input int pat);
      logic [DW-1:0] v;
      for (int i = 0; i < n; i++) begin
         if (mode == 1 && i != 0) idle_cycle();
         if (mode == 2 && m_col == W-1)
            for (int g = 0; g < 10; g++) idle_cycle();
         if (pat == 1)
            v = ((((m_row >> 1) ^ (m_col >> 1)) & 1) != 0) ? 8'hFF : 8'h00;
         else
            v = DW'(offset + m_row*W + m_col);
         push_pixel(v);
      end
   endtask

   task automatic finish_test(input string tag, input int exp_win, input int exp_fd);
      for (int i = 0; i < 3; i++) idle_cycle();
      check_eq({tag, "_win_count"}, WB'(win_cnt), WB'(exp_win));
      check_eq({tag, "_fd_count"}, WB'(fd_cnt), WB'(exp_fd));
      check_eq({tag, "_sb_drained"}, WB'(sb.size()), '0);
      win_cnt = 0;
      fd_cnt  = 0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_win_out"}, win_out, '0);
      check_eq({tag, "_win_valid"}, WB'(win_valid), '0);
      check_eq({tag, "_win_row"}, WB'(win_row), '0);
      check_eq({tag, "_win_col"}, WB'(win_col), '0);
      check_eq({tag, "_frame_done"}, WB'(frame_done), '0);
   endtask

   always @(posedge clk) acc_q <= valid_in & rst_n;

   always @(negedge clk) begin
      if (rst_n) begin
         if (win_valid) begin
            check_eq("wv_after_accept", WB'(acc_q), WB'(1));
            if (tog_mode) check_eq("wv_consecutive", WB'(prev_wv), '0);
            win_cnt++;
            obs_win[win_row][win_col] = win_out;
            check_eq("sb_nonempty", WB'(sb.size() != 0), WB'(1));
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check_eq("win", win_out, e.win);
               check_eq("row", WB'(win_row), WB'(e.row));
               check_eq("col", WB'(win_col), WB'(e.col));
               check_eq("frame_done", WB'(frame_done), WB'(e.fd));
            end
         end else if (frame_done) begin
            check_eq("fd_without_window", WB'(frame_done), '0);
         end
         if (frame_done) begin
            fd_cnt++;
            check_eq("fd_after_accept", WB'(acc_q), WB'(1));
         end
         prev_wv = win_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; valid_in = 1'b0; pixel_in = '0;
      m_row = 0; m_col = 0; win_cnt = 0; fd_cnt = 0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst_n = 1'b1;
      idle_cycle();

      send_pixels(64, 0, 0, 0);
      finish_test("t1", 36, 1);
      check_eq("t1_first", obs_win[1][1], pack9(0, 1, 2, 8, 9, 10, 16, 17, 18));
      check_eq("t1_last_slot8", WB'(obs_win[6][6][8*DW +: DW]), WB'(63));

      send_pixels(64, 0, 0, 1);
      finish_test("t2", 36, 1);
      check_eq("t2_c11", obs_win[1][1], pack9(8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00));
      check_eq("t2_c22", obs_win[2][2], pack9(8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00));

      tog_mode = 1'b1;
      send_pixels(64, 0, 1, 0);
      finish_test("t3", 36, 1);
      tog_mode = 1'b0;

      send_pixels(64, 0, 0, 0);
      send_pixels(64, 64, 0, 0);
      finish_test("t4", 72, 2);
      check_eq("t4_f2_first", obs_win[1][1], pack9(64, 65, 66, 72, 73, 74, 80, 81, 82));

      send_pixels(20, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("t5_async");
      sb.delete();
      m_row = 0; m_col = 0; win_cnt = 0; fd_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_cycle();
      send_pixels(64, 0, 0, 0);
      finish_test("t5", 36, 1);
      check_eq("t5_first", obs_win[1][1], pack9(0, 1, 2, 8, 9, 10, 16, 17, 18));

      send_pixels(64, 0, 2, 0);
      finish_test("t6", 36, 1);
      check_eq("t6_last_slot8", WB'(obs_win[6][6][8*DW +: DW]), WB'(63));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
